// File: rtl/mem_access_unit.sv
// Sequencer between the MAR/MDR datapath and a 16-bit asynchronous SRAM.
// One request at a time, programmable wait states, all strobes registered.
module mem_access_unit #(
  parameter int WAIT_STATES = 2,
  parameter int ADDR_W      = 20
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_write,
  input  logic [15:0]       i_req_addr,
  input  logic [15:0]       i_req_data,
  output logic              o_rsp_valid,
  output logic [15:0]       o_rsp_data,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [15:0]       o_mem_data_out,
  output logic              o_mem_data_oe,
  input  logic [15:0]       i_mem_data_in,
  output logic              o_ce_n,
  output logic              o_oe_n,
  output logic              o_we_n,
  output logic              o_ub_n,
  output logic              o_lb_n
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t            r_state;
  logic [3:0]        r_count;
  logic              r_write;
  logic              r_rsp_valid;
  logic [15:0]       r_rsp_data;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [15:0]       r_mem_data_out;
  logic              r_mem_data_oe;
  logic              r_ce_n;
  logic              r_oe_n;
  logic              r_we_n;
  logic              r_ub_n;
  logic              r_lb_n;
  logic              w_accept;

  assign o_req_ready = (r_state == IDLE) && !i_reset;
  assign w_accept    = i_req_valid && o_req_ready;

  // Strobes are set on the same edge that changes state, so they never glitch.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state        <= IDLE;
      r_count        <= 4'd0;
      r_write        <= 1'b0;
      r_rsp_valid    <= 1'b0;
      r_rsp_data     <= 16'h0000;
      r_mem_addr     <= '0;
      r_mem_data_out <= 16'h0000;
      r_mem_data_oe  <= 1'b0;
      r_ce_n         <= 1'b1;
      r_oe_n         <= 1'b1;
      r_we_n         <= 1'b1;
      r_ub_n         <= 1'b1;
      r_lb_n         <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          r_rsp_valid <= 1'b0;
          if (w_accept) begin
            r_write        <= i_req_write;
            r_mem_addr     <= ADDR_W'(i_req_addr);
            r_mem_data_out <= i_req_data;
            r_count        <= 4'(WAIT_STATES);
            r_ce_n         <= 1'b0;
            r_ub_n         <= 1'b0;
            r_lb_n         <= 1'b0;
            r_oe_n         <= i_req_write;
            r_we_n         <= !i_req_write;
            r_mem_data_oe  <= i_req_write;
            r_state        <= ACCESS;
          end
        end
        ACCESS: begin
          if (r_count == 4'd0) begin
            r_ce_n      <= 1'b1;
            r_oe_n      <= 1'b1;
            r_we_n      <= 1'b1;
            r_ub_n      <= 1'b1;
            r_lb_n      <= 1'b1;
            r_rsp_valid <= 1'b1;
            if (!r_write) begin
              r_rsp_data <= i_mem_data_in;
            end
            r_state <= DONE;
          end else begin
            r_count <= r_count - 4'd1;
          end
        end
        DONE: begin
          // Data stays driven here to give one cycle of hold after WE_N rises.
          r_rsp_valid   <= 1'b0;
          r_mem_data_oe <= 1'b0;
          r_state       <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_rsp_valid    = r_rsp_valid;
  assign o_rsp_data     = r_rsp_data;
  assign o_mem_addr     = r_mem_addr;
  assign o_mem_data_out = r_mem_data_out;
  assign o_mem_data_oe  = r_mem_data_oe;
  assign o_ce_n         = r_ce_n;
  assign o_oe_n         = r_oe_n;
  assign o_we_n         = r_we_n;
  assign o_ub_n         = r_ub_n;
  assign o_lb_n         = r_lb_n;

endmodule
